ucsbece154b_icache_lru: RTL and testbench

UCSBECE154B_ICACHE_LRU -- requirements
Module: ucsbece154b_icache_lru

---
 rtl/ucsbece154b_icache_lru.sv | 274 +++++++++++++++++++++++++++
 tb/tb_ucsbece154b_icache_lru.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/ucsbece154b_icache_lru.sv
// Set-associative instruction cache with per-set age-counter LRU replacement.
// Define ICACHE_CWF_EN for critical-word-first refill with early restart.
module ucsbece154b_icache_lru #(
  parameter int NUM_SETS    = 8,
  parameter int NUM_WAYS    = 4,
  parameter int BLOCK_WORDS = 4,
  parameter int WORD_SIZE   = 32
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 ReadEnable,
  input  logic [31:0]          ReadAddress,
  input  logic                 Invalidate,
  output logic [WORD_SIZE-1:0] Instruction,
  output logic                 Ready,
  output logic                 Busy,
  output logic [31:0]          MemReadAddress,
  output logic                 MemReadRequest,
  input  logic [31:0]          MemDataIn,
  input  logic                 MemDataReady
);

  localparam int OFF_W = $clog2(BLOCK_WORDS);
  localparam int SET_W = $clog2(NUM_SETS);
  localparam int WAY_W = $clog2(NUM_WAYS);
  localparam int TAG_W = 32 - 2 - OFF_W - SET_W;
  localparam logic [WAY_W-1:0] MAX_AGE = WAY_W'(NUM_WAYS - 1);

  typedef logic [NUM_WAYS-1:0][WAY_W-1:0] ages_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REQ    = 3'd1,
    REFILL = 3'd2,
    RESP   = 3'd3,
    INVAL  = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [WORD_SIZE-1:0]   data_q [NUM_SETS][NUM_WAYS][BLOCK_WORDS];
  logic [NUM_WAYS-1:0]    valid_q [NUM_SETS];
  logic [NUM_WAYS-1:0]    valid_d [NUM_SETS];
  logic [TAG_W-1:0]       tag_arr_q [NUM_SETS][NUM_WAYS];
  logic [TAG_W-1:0]       tag_arr_d [NUM_SETS][NUM_WAYS];
  ages_t                  age_q [NUM_SETS];
  ages_t                  age_d [NUM_SETS];
  logic [OFF_W-1:0]       beat_q, beat_d;
  logic [OFF_W-1:0]       req_word_q, req_word_d;
  logic [SET_W-1:0]       req_set_q, req_set_d;
  logic [TAG_W-1:0]       req_tag_q, req_tag_d;
  logic [WAY_W-1:0]       victim_q, victim_d;
  logic                   pend_inv_q, pend_inv_d;
  logic [WORD_SIZE-1:0]   instr_q, instr_d;
  logic                   ready_q, ready_d;
  logic                   busy_q, busy_d;
  logic [31:0]            mem_addr_q, mem_addr_d;
  logic                   mem_req_q, mem_req_d;
  logic                   data_we;

  logic [OFF_W-1:0]       rd_word;
  logic [SET_W-1:0]       rd_set;
  logic [TAG_W-1:0]       rd_tag;
  logic                   hit;
  logic [WAY_W-1:0]       hit_way;
  logic [OFF_W-1:0]       beat_inc;
  logic [OFF_W-1:0]       fill_start;
  logic                   unused_addr_bits;

  assign rd_word          = ReadAddress[2 +: OFF_W];
  assign rd_set           = ReadAddress[2 + OFF_W +: SET_W];
  assign rd_tag           = ReadAddress[31 -: TAG_W];
  assign unused_addr_bits = ^ReadAddress[1:0];
  assign beat_inc         = beat_q + OFF_W'(1);

`ifdef ICACHE_CWF_EN
  assign fill_start = req_word_q;
`else
  assign fill_start = '0;
`endif

  // Ages stay a permutation once a set is full; ties from an all-zero start resolve by touch order.
  function automatic ages_t lru_touch(input ages_t ages, input logic [WAY_W-1:0] way);
    ages_t res;
    res = ages;
    for (int i = 0; i < NUM_WAYS; i++) begin
      if (i == int'(way)) begin
        res[i] = '0;
      end else if ((ages[i] <= ages[way]) && (ages[i] != MAX_AGE)) begin
        res[i] = ages[i] + WAY_W'(1);
      end
    end
    return res;
  endfunction

  function automatic logic [WAY_W-1:0] pick_victim(input logic [NUM_WAYS-1:0] vld, input ages_t ages);
    logic [WAY_W-1:0] way;
    logic [WAY_W-1:0] oldest;
    way    = '0;
    oldest = ages[0];
    for (int i = 1; i < NUM_WAYS; i++) begin
      if (ages[i] > oldest) begin
        oldest = ages[i];
        way    = WAY_W'(i);
      end
    end
    for (int i = NUM_WAYS - 1; i >= 0; i--) begin
      if (!vld[i]) way = WAY_W'(i);
    end
    return way;
  endfunction

  // Tag lookup for the incoming request
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (valid_q[rd_set][w] && (tag_arr_q[rd_set][w] == rd_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  // Next-state and output logic
  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    tag_arr_d  = tag_arr_q;
    age_d      = age_q;
    beat_d     = beat_q;
    req_word_d = req_word_q;
    req_set_d  = req_set_q;
    req_tag_d  = req_tag_q;
    victim_d   = victim_q;
    pend_inv_d = pend_inv_q;
    instr_d    = instr_q;
    ready_d    = 1'b0;
    busy_d     = busy_q;
    mem_addr_d = mem_addr_q;
    mem_req_d  = mem_req_q;
    data_we    = 1'b0;

    case (state_q)
      IDLE, RESP: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        if (Invalidate || pend_inv_q) begin
          state_d    = INVAL;
          busy_d     = 1'b1;
          pend_inv_d = 1'b0;
        end else if (ReadEnable) begin
          if (hit) begin
            ready_d        = 1'b1;
            instr_d        = data_q[rd_set][hit_way][rd_word];
            age_d[rd_set]  = lru_touch(age_q[rd_set], hit_way);
          end else begin
            state_d    = REQ;
            busy_d     = 1'b1;
            mem_req_d  = 1'b1;
            req_word_d = rd_word;
            req_set_d  = rd_set;
            req_tag_d  = rd_tag;
            victim_d   = pick_victim(valid_q[rd_set], age_q[rd_set]);
`ifdef ICACHE_CWF_EN
            mem_addr_d = {ReadAddress[31:2], 2'b00};
            beat_d     = rd_word;
`else
            mem_addr_d = {ReadAddress[31:2 + OFF_W], {(OFF_W + 2){1'b0}}};
            beat_d     = '0;
`endif
          end
        end
      end
      REQ: begin
        if (Invalidate) pend_inv_d = 1'b1;
        if (MemDataReady) begin
          data_we   = 1'b1;
          beat_d    = beat_inc;
          mem_req_d = 1'b0;
          state_d   = REFILL;
`ifdef ICACHE_CWF_EN
          // Early restart: the first beat is always the requested word.
          ready_d   = 1'b1;
          instr_d   = WORD_SIZE'(MemDataIn);
`endif
        end
      end
      REFILL: begin
        if (Invalidate) pend_inv_d = 1'b1;
        if (MemDataReady) begin
          data_we = 1'b1;
          beat_d  = beat_inc;
          if (beat_inc == fill_start) begin
            valid_d[req_set_q][victim_q]   = 1'b1;
            tag_arr_d[req_set_q][victim_q] = req_tag_q;
            age_d[req_set_q]               = lru_touch(age_q[req_set_q], victim_q);
            busy_d                         = 1'b0;
`ifdef ICACHE_CWF_EN
            state_d = IDLE;
`else
            state_d = RESP;
            ready_d = 1'b1;
            instr_d = (beat_q == req_word_q) ? WORD_SIZE'(MemDataIn)
                                             : data_q[req_set_q][victim_q][req_word_q];
`endif
          end
        end
      end
      INVAL: begin
        for (int s = 0; s < NUM_SETS; s++) begin
          valid_d[s] = '0;
          age_d[s]   = '0;
        end
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Control, tag, valid and LRU registers
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= IDLE;
      valid_q    <= '{default: '0};
      tag_arr_q  <= '{default: '0};
      age_q      <= '{default: '0};
      beat_q     <= '0;
      req_word_q <= '0;
      req_set_q  <= '0;
      req_tag_q  <= '0;
      victim_q   <= '0;
      pend_inv_q <= 1'b0;
      instr_q    <= '0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      mem_addr_q <= 32'd0;
      mem_req_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      tag_arr_q  <= tag_arr_d;
      age_q      <= age_d;
      beat_q     <= beat_d;
      req_word_q <= req_word_d;
      req_set_q  <= req_set_d;
      req_tag_q  <= req_tag_d;
      victim_q   <= victim_d;
      pend_inv_q <= pend_inv_d;
      instr_q    <= instr_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      mem_addr_q <= mem_addr_d;
      mem_req_q  <= mem_req_d;
    end
  end

  // Line data storage; contents are meaningless until the valid bit is set
  always_ff @(posedge Clk) begin
    if (data_we && !Reset) begin
      data_q[req_set_q][victim_q][beat_q] <= WORD_SIZE'(MemDataIn);
    end
  end

  assign Instruction    = instr_q;
  assign Ready          = ready_q;
  assign Busy           = busy_q;
  assign MemReadAddress = mem_addr_q;
  assign MemReadRequest = mem_req_q;

endmodule

// File: tb/tb_ucsbece154b_icache_lru.sv
// Scoreboard bench for ucsbece154b_icache_lru: expected words are queued at issue
// and popped by a monitor on every Ready pulse.
module tb_ucsbece154b_icache_lru;

`ifdef ICACHE_CWF_EN
  localparam bit CWF = 1'b1;
`else
  localparam bit CWF = 1'b0;
`endif

  logic        Clk = 1'b0;
  logic        Reset, ReadEnable, Invalidate, MemDataReady;
  logic [31:0] ReadAddress, MemDataIn;
  logic [31:0] Instruction, MemReadAddress;
  logic        Ready, Busy, MemReadRequest;

  int          n_chk = 0;
  int          n_fail = 0;
  int          ready_cnt = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mon_exp;

  always #5 Clk = ~Clk;

  ucsbece154b_icache_lru #(
    .NUM_SETS(8), .NUM_WAYS(4), .BLOCK_WORDS(4), .WORD_SIZE(32)
  ) dut (
    .Clk(Clk), .Reset(Reset), .ReadEnable(ReadEnable), .ReadAddress(ReadAddress),
    .Invalidate(Invalidate), .Instruction(Instruction), .Ready(Ready), .Busy(Busy),
    .MemReadAddress(MemReadAddress), .MemReadRequest(MemReadRequest),
    .MemDataIn(MemDataIn), .MemDataReady(MemDataReady)
  );

  // Backing memory: line 0x40 holds 0xA0..0xA3, everything else is address-tagged
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    if (a[31:4] == 28'h4) w = 32'hA0 + {30'd0, a[3:2]};
    else                  w = 32'hC000_0000 | a;
    return w;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge Clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ready"}, {31'd0, Ready}, 32'd0);
    chk({tag, "_busy"}, {31'd0, Busy}, 32'd0);
    chk({tag, "_memreq"}, {31'd0, MemReadRequest}, 32'd0);
    chk({tag, "_memaddr"}, MemReadAddress, 32'd0);
    chk({tag, "_instr"}, Instruction, 32'd0);
  endtask

  task automatic wait_idle();
    int zeros = 0;
    int cyc = 0;
    while (zeros < 2 && cyc < 40) begin
      tick();
      cyc++;
      if (Busy == 1'b0) zeros++;
      else zeros = 0;
    end
    n_chk++;
    if (zeros < 2) begin
      n_fail++;
      $display("FAIL idle_timeout: Busy=%0b after %0d cycles, expected 0", Busy, cyc);
    end
  endtask

  task automatic hit(input logic [31:0] a);
    ReadEnable = 1'b1;
    ReadAddress = a;
    exp_q.push_back(mem_word(a));
    tick();
    ReadEnable = 1'b0;
    chk("hit_ready", {31'd0, Ready}, 32'd1);
    chk("hit_busy", {31'd0, Busy}, 32'd0);
    chk("hit_memreq", {31'd0, MemReadRequest}, 32'd0);
  endtask

  task automatic miss(input logic [31:0] a, input int gap, input int inv_beat,
                      input int rst_beat, input bit toggle);
    int rc0;
    logic [1:0] st, wi;
    rc0 = ready_cnt;
    ReadEnable = 1'b1;
    ReadAddress = a;
    exp_q.push_back(mem_word(a));
    tick();
    ReadEnable = 1'b0;
    chk("miss_memreq", {31'd0, MemReadRequest}, 32'd1);
    chk("miss_busy", {31'd0, Busy}, 32'd1);
    chk("miss_memaddr", MemReadAddress, CWF ? (a & ~32'h3) : (a & ~32'hF));
    st = CWF ? a[3:2] : 2'd0;
    for (int k = 0; k < 4; k++) begin
      for (int g = 0; g < gap; g++) begin
        if (toggle) begin
          ReadEnable = (g % 2 == 0);
          ReadAddress = 32'h500;
        end
        tick();
        if (k == 0) chk("memreq_held", {31'd0, MemReadRequest}, 32'd1);
      end
      ReadEnable = 1'b0;
      wi = st + k[1:0];
      MemDataReady = 1'b1;
      MemDataIn = mem_word({a[31:4], wi, 2'b00});
      Invalidate = (k == inv_beat);
      Reset = (k == rst_beat);
      tick();
      MemDataReady = 1'b0;
      Invalidate = 1'b0;
      if (k == rst_beat) begin
        Reset = 1'b0;
        exp_q.delete();
        chk_zero("midrst");
        for (int j = k + 1; j < 4; j++) begin
          MemDataReady = 1'b1;
          MemDataIn = 32'hDEAD_0000 | j;
          tick();
          MemDataReady = 1'b0;
          chk("stale_beat_busy", {31'd0, Busy}, 32'd0);
        end
        tick();
        chk("rst_ready_count", ready_cnt - rc0, (CWF && rst_beat > 0) ? 32'd1 : 32'd0);
        return;
      end
      if (k == 0) chk("memreq_drop", {31'd0, MemReadRequest}, 32'd0);
    end
    wait_idle();
    chk("one_ready", ready_cnt - rc0, 32'd1);
  endtask

  // Monitor: every Ready pulse must match the oldest outstanding expectation
  always @(negedge Clk) begin
    if (Ready === 1'b1) begin
      ready_cnt++;
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_ready: got Instruction %h, expected no Ready", Instruction);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("ready_instr", Instruction, mon_exp);
      end
    end
  end

  initial begin
    Reset = 1'b1; ReadEnable = 1'b0; ReadAddress = 32'd0; Invalidate = 1'b0;
    MemDataReady = 1'b0; MemDataIn = 32'd0;
    repeat (3) tick();
    chk_zero("reset");
    Reset = 1'b0;
    tick();

    // Cold miss then 1-cycle back-to-back hits in the same line
    miss(32'h48, 0, -1, -1, 1'b0);
    hit(32'h4C);
    hit(32'h40);
    hit(32'h44);
    tick();

    // LRU: fill set 0, re-touch 0x000, fifth tag must evict 0x080
    miss(32'h000, 0, -1, -1, 1'b0);
    miss(32'h080, 1, -1, -1, 1'b0);
    miss(32'h100, 0, -1, -1, 1'b0);
    miss(32'h180, 0, -1, -1, 1'b0);
    hit(32'h000);
    tick();
    miss(32'h200, 0, -1, -1, 1'b0);
    hit(32'h004);
    tick();
    miss(32'h080, 0, -1, -1, 1'b0);

    // Invalidate with a simultaneous request: request dropped, one busy cycle
    Invalidate = 1'b1;
    ReadEnable = 1'b1;
    ReadAddress = 32'h000;
    tick();
    Invalidate = 1'b0;
    ReadEnable = 1'b0;
    chk("inval_busy", {31'd0, Busy}, 32'd1);
    chk("inval_memreq", {31'd0, MemReadRequest}, 32'd0);
    tick();
    chk("inval_done", {31'd0, Busy}, 32'd0);
    miss(32'h000, 1, -1, -1, 1'b0);

    // Invalidate during refill is deferred, then the line is gone
    miss(32'h300, 1, 1, -1, 1'b0);
    miss(32'h300, 0, -1, -1, 1'b0);

    // Reset during the second beat abandons the refill
    miss(32'h500, 0, -1, 1, 1'b0);
    miss(32'h500, 0, -1, -1, 1'b0);

    // Requests toggled while busy are ignored; sparse beats still fill the line
    miss(32'h600, 3, -1, -1, 1'b1);
    hit(32'h60C);
    tick();

    // Stray beat while idle is ignored
    MemDataReady = 1'b1;
    MemDataIn = 32'h1234_5678;
    tick();
    MemDataReady = 1'b0;
    chk("stray_busy", {31'd0, Busy}, 32'd0);
    chk("stray_memreq", {31'd0, MemReadRequest}, 32'd0);
    tick();
    chk("queue_empty", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
